// File: rtl/converge_counter_mc.sv
// Multi-channel converging counter pair: i climbs, j descends, each channel halts in DONE or OVF.
// Optional per-channel saturating step counter enabled by defining CONV_STEP_CNT_EN.
module converge_counter_mc #(
   parameter int CH     = 2,
   parameter int WIDTH  = 15,
   parameter int I_INIT = 1,
   parameter int J_INIT = 1000,
   parameter int I_STEP = 2,
   parameter int J_STEP = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CH-1:0]         sel,
   input  logic [CH-1:0]         load,
   input  logic [CH*WIDTH-1:0]   load_i,
   input  logic [CH*WIDTH-1:0]   load_j,
   output logic [CH*WIDTH-1:0]   i_out,
   output logic [CH*WIDTH-1:0]   j_out,
   output logic [CH-1:0]         done,
   output logic [CH-1:0]         ovf,
   output logic [CH*WIDTH-1:0]   steps
);

   typedef enum logic [1:0] {RUN, DONE, OVF} state_t;

   localparam logic [WIDTH:0]   MAX_W    = {1'b0, {WIDTH{1'b1}}};
   localparam logic [WIDTH:0]   I_STEP_W = (WIDTH+1)'(I_STEP);
   localparam logic [WIDTH:0]   J_STEP_W = (WIDTH+1)'(J_STEP);
   localparam logic [WIDTH-1:0] I_RST    = WIDTH'(I_INIT);
   localparam logic [WIDTH-1:0] J_RST    = WIDTH'(J_INIT);

   for (genvar c = 0; c < CH; c++) begin : g_ch
      state_t           state;
      logic [WIDTH-1:0] i_q;
      logic [WIDTH-1:0] j_q;
      logic             done_q;
      logic             ovf_q;
      logic [WIDTH:0]   i_sum;
      logic [WIDTH-1:0] i_nxt;
      logic [WIDTH-1:0] j_nxt;
      logic             crossed;
      logic             wraps;
      logic             take_step;

      // Overflow is judged one bit wider so the wrap is seen before it happens.
      always_comb begin
         i_sum     = {1'b0, i_q} + I_STEP_W;
         i_nxt     = i_sum[WIDTH-1:0];
         j_nxt     = j_q - J_STEP_W[WIDTH-1:0];
         crossed   = (j_q < i_q);
         wraps     = (i_sum > MAX_W) || ({1'b0, j_q} < J_STEP_W);
         take_step = (state == RUN) && !load[c] && sel[c] && !crossed && !wraps;
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            state  <= RUN;
            i_q    <= I_RST;
            j_q    <= J_RST;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
         end else if (load[c]) begin
            state  <= RUN;
            i_q    <= load_i[c*WIDTH +: WIDTH];
            j_q    <= load_j[c*WIDTH +: WIDTH];
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
         end else if (state == RUN) begin
            if (crossed) begin
               state  <= DONE;
               done_q <= 1'b1;
            end else if (sel[c]) begin
               if (wraps) begin
                  state <= OVF;
                  ovf_q <= 1'b1;
               end else begin
                  i_q <= i_nxt;
                  j_q <= j_nxt;
                  // A step that crosses the counters lands in DONE on the same edge.
                  if (j_nxt < i_nxt) begin
                     state  <= DONE;
                     done_q <= 1'b1;
                  end
               end
            end
         end
      end

`ifdef CONV_STEP_CNT_EN
      logic [WIDTH-1:0] steps_q;

      always_ff @(posedge clk) begin
         if (rst || load[c]) begin
            steps_q <= '0;
         end else if (take_step && (steps_q != {WIDTH{1'b1}})) begin
            steps_q <= steps_q + 1'b1;
         end
      end

      assign steps[c*WIDTH +: WIDTH] = steps_q;
`else
      assign steps[c*WIDTH +: WIDTH] = '0;
`endif

      assign i_out[c*WIDTH +: WIDTH] = i_q;
      assign j_out[c*WIDTH +: WIDTH] = j_q;
      assign done[c]                 = done_q;
      assign ovf[c]                  = ovf_q;
   end

endmodule

// File: tb/tb_converge_counter_mc.sv
// Self-checking bench for converge_counter_mc: cycle scoreboard against a behavioural model,
// plus fixed-value checks and a narrow WIDTH=4 instance for overflow cases.
module tb_converge_counter_mc;

   localparam int W  = 15;
   localparam int W4 = 4;
`ifdef CONV_STEP_CNT_EN
   localparam bit STEP_EN = 1'b1;
`else
   localparam bit STEP_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    sel, load;
   logic [2*W-1:0] load_i, load_j, i_out, j_out, steps;
   logic [1:0]    done, ovf;

   logic [1:0]      sel4, load4;
   logic [2*W4-1:0] load_i4, load_j4, i_out4, j_out4, steps4;
   logic [1:0]      done4, ovf4;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2*W-1:0] i;
      logic [2*W-1:0] j;
      logic [2*W-1:0] st;
      logic [1:0]     dn;
      logic [1:0]     ov;
   } exp_t;

   exp_t exp_q[$];

   // Behavioural model: 0 = RUN, 1 = DONE, 2 = OVF
   int m_i[2], m_j[2], m_st[2], m_steps[2];

   always #5 clk = ~clk;

   converge_counter_mc dut (
      .clk(clk), .rst(rst), .sel(sel), .load(load),
      .load_i(load_i), .load_j(load_j),
      .i_out(i_out), .j_out(j_out), .done(done), .ovf(ovf), .steps(steps)
   );

   converge_counter_mc #(.WIDTH(W4), .J_INIT(15)) dut4 (
      .clk(clk), .rst(rst), .sel(sel4), .load(load4),
      .load_i(load_i4), .load_j(load_j4),
      .i_out(i_out4), .j_out(j_out4), .done(done4), .ovf(ovf4), .steps(steps4)
   );

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive one cycle on the main DUT, advance the model, score after the edge.
   task automatic applyStimulus(input logic r, input logic [1:0] s, input logic [1:0] l,
                                input int li, input int lj);
      exp_t e;
      exp_t got;
      rst    = r;
      sel    = s;
      load   = l;
      load_i = {W'(li), W'(li)};
      load_j = {W'(lj), W'(lj)};
      for (int c = 0; c < 2; c++) begin
         if (r) begin
            m_i[c] = 1; m_j[c] = 1000; m_st[c] = 0; m_steps[c] = 0;
         end else if (l[c]) begin
            m_i[c] = li; m_j[c] = lj; m_st[c] = 0; m_steps[c] = 0;
         end else if (m_st[c] == 0) begin
            if (m_j[c] < m_i[c]) m_st[c] = 1;
            else if (s[c]) begin
               if (m_i[c] + 2 > 32767 || m_j[c] < 1) m_st[c] = 2;
               else begin
                  m_i[c] += 2;
                  m_j[c] -= 1;
                  if (m_steps[c] < 32767) m_steps[c]++;
                  if (m_j[c] < m_i[c]) m_st[c] = 1;
               end
            end
         end
         e.i[c*W +: W]  = W'(m_i[c]);
         e.j[c*W +: W]  = W'(m_j[c]);
         e.st[c*W +: W] = STEP_EN ? W'(m_steps[c]) : '0;
         e.dn[c]        = (m_st[c] == 1);
         e.ov[c]        = (m_st[c] == 2);
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      got = exp_q.pop_front();
      checkOutput("sb_i", 64'(i_out), 64'(got.i));
      checkOutput("sb_j", 64'(j_out), 64'(got.j));
      checkOutput("sb_steps", 64'(steps), 64'(got.st));
      checkOutput("sb_done", 64'(done), 64'(got.dn));
      checkOutput("sb_ovf", 64'(ovf), 64'(got.ov));
   endtask

   task automatic checkChan(input string tag, input int c, input int ei, input int ej,
                            input logic ed, input logic eo, input int es);
      checkOutput({tag, "_i"}, 64'(i_out[c*W +: W]), 64'(ei));
      checkOutput({tag, "_j"}, 64'(j_out[c*W +: W]), 64'(ej));
      checkOutput({tag, "_done"}, 64'(done[c]), 64'(ed));
      checkOutput({tag, "_ovf"}, 64'(ovf[c]), 64'(eo));
      checkOutput({tag, "_steps"}, 64'(steps[c*W +: W]), STEP_EN ? 64'(es) : 64'd0);
   endtask

   task automatic applyStim4(input logic s, input logic l, input int li, input int lj);
      sel4    = {1'b0, s};
      load4   = {1'b0, l};
      load_i4 = {4'd0, W4'(li)};
      load_j4 = {4'd0, W4'(lj)};
      @(posedge clk);
      #1;
   endtask

   task automatic checkChan4(input string tag, input int ei, input int ej,
                             input logic ed, input logic eo);
      checkOutput({tag, "_i"}, 64'(i_out4[W4-1:0]), 64'(ei));
      checkOutput({tag, "_j"}, 64'(j_out4[W4-1:0]), 64'(ej));
      checkOutput({tag, "_done"}, 64'(done4[0]), 64'(ed));
      checkOutput({tag, "_ovf"}, 64'(ovf4[0]), 64'(eo));
   endtask

   initial begin
      sel4 = '0; load4 = '0; load_i4 = '0; load_j4 = '0;

      // Reset state on both instances
      applyStimulus(1'b1, 2'b00, 2'b00, 0, 0);
      checkChan("rst0", 0, 1, 1000, 1'b0, 1'b0, 0);
      checkChan("rst1", 1, 1, 1000, 1'b0, 1'b0, 0);
      checkChan4("rst4", 1, 15, 1'b0, 1'b0);

      // Narrow instance: i-wrap overflow, recovery by load, j-underflow overflow
      rst = 1'b0; sel = '0; load = '0;
      applyStim4(1'b1, 1'b1, 14, 15);
      checkChan4("w4_load", 14, 15, 1'b0, 1'b0);
      applyStim4(1'b1, 1'b0, 0, 0);
      checkChan4("w4_ovf", 14, 15, 1'b0, 1'b1);
      applyStim4(1'b1, 1'b0, 0, 0);
      checkChan4("w4_ovf_hold", 14, 15, 1'b0, 1'b1);
      applyStim4(1'b0, 1'b1, 1, 3);
      checkChan4("w4_reload", 1, 3, 1'b0, 1'b0);
      applyStim4(1'b1, 1'b0, 0, 0);
      checkChan4("w4_cross", 3, 2, 1'b1, 1'b0);
      applyStim4(1'b0, 1'b1, 0, 0);
      applyStim4(1'b1, 1'b0, 0, 0);
      checkChan4("w4_jovf", 0, 0, 1'b0, 1'b1);
      applyStim4(1'b0, 1'b0, 0, 0);

      // Both channels converge with sel held high
      applyStimulus(1'b1, 2'b00, 2'b00, 0, 0);
      for (int k = 0; k < 334; k++) applyStimulus(1'b0, 2'b11, 2'b00, 0, 0);
      checkChan("conv0", 0, 669, 666, 1'b1, 1'b0, 334);
      checkChan("conv1", 1, 669, 666, 1'b1, 1'b0, 334);
      for (int k = 0; k < 10; k++) applyStimulus(1'b0, 2'b11, 2'b00, 0, 0);
      checkChan("hold0", 0, 669, 666, 1'b1, 1'b0, 334);

      // Load out of DONE together with sel: load wins, then two steps
      applyStimulus(1'b0, 2'b11, 2'b01, 1, 4);
      checkChan("reload", 0, 1, 4, 1'b0, 1'b0, 0);
      applyStimulus(1'b0, 2'b11, 2'b00, 0, 0);
      checkChan("rl_step1", 0, 3, 3, 1'b0, 1'b0, 1);
      applyStimulus(1'b0, 2'b11, 2'b00, 0, 0);
      checkChan("rl_step2", 0, 5, 2, 1'b1, 1'b0, 2);
      checkChan("rl_other", 1, 669, 666, 1'b1, 1'b0, 334);

      // Channel 0 stepped every other cycle, channel 1 idle
      applyStimulus(1'b1, 2'b00, 2'b00, 0, 0);
      for (int k = 0; k < 668; k++) applyStimulus(1'b0, {1'b0, (k % 2 == 0)}, 2'b00, 0, 0);
      checkChan("tog0", 0, 669, 666, 1'b1, 1'b0, 334);
      checkChan("tog1", 1, 1, 1000, 1'b0, 1'b0, 0);

      // Load already crossed: values first, DONE one edge later
      applyStimulus(1'b0, 2'b00, 2'b01, 20, 10);
      checkChan("xload", 0, 20, 10, 1'b0, 1'b0, 0);
      applyStimulus(1'b0, 2'b00, 2'b00, 0, 0);
      checkChan("xdone", 0, 20, 10, 1'b1, 1'b0, 0);

      // Reset wins over load and sel mid-run
      applyStimulus(1'b1, 2'b00, 2'b00, 0, 0);
      for (int k = 0; k < 100; k++) applyStimulus(1'b0, 2'b11, 2'b00, 0, 0);
      checkChan("mid100", 1, 201, 900, 1'b0, 1'b0, 100);
      applyStimulus(1'b1, 2'b11, 2'b11, 7, 9);
      checkChan("rstwin0", 0, 1, 1000, 1'b0, 1'b0, 0);
      checkChan("rstwin1", 1, 1, 1000, 1'b0, 1'b0, 0);

      // Near the top of the range: i would wrap on the next step
      applyStimulus(1'b0, 2'b00, 2'b01, 32766, 32767);
      applyStimulus(1'b0, 2'b01, 2'b00, 0, 0);
      checkChan("ovf15", 0, 32766, 32767, 1'b0, 1'b1, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
